// File: rtl/rs.sv
`default_nettype none
// ============================================================================
// Module   : rs
// Brief    : ALU-path reservation station; wakes operands from ALU/LSB
//            broadcasts and issues one ready entry per cycle, registered.
// Revision : 1.0
// ============================================================================
module rs #(
  parameter int RS_SIZE  = 16,
  parameter int OPNUM_W  = 6,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  // dispatch
  input  logic                en_from_dsp,
  input  logic [OPNUM_W-1:0]  opnum_from_dsp,
  input  logic [31:0]         V1_from_dsp,
  input  logic [31:0]         V2_from_dsp,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  input  logic                W1_from_dsp,
  input  logic                W2_from_dsp,
  input  logic [31:0]         imm_from_dsp,
  input  logic [31:0]         pc_from_dsp,
  input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
  output logic                full_to_dsp,
  // result broadcasts
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [31:0]         alu_data,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_data,
  input  logic                rollback,
  // issue
  output logic [OPNUM_W-1:0]  opnum_to_ex,
  output logic [31:0]         V1_to_ex,
  output logic [31:0]         V2_to_ex,
  output logic [31:0]         imm_to_ex,
  output logic [31:0]         pc_to_ex,
  output logic [ROB_ID_W-1:0] rob_id_to_ex
);

  localparam logic [OPNUM_W-1:0] OPNUM_NULL = '0;
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  // Entry storage
  logic [RS_SIZE-1:0]  busy_q, busy_d;
  logic [RS_SIZE-1:0]  w1_q, w1_d;
  logic [RS_SIZE-1:0]  w2_q, w2_d;
  logic [OPNUM_W-1:0]  opnum_q [RS_SIZE];
  logic [OPNUM_W-1:0]  opnum_d [RS_SIZE];
  logic [31:0]         v1_q    [RS_SIZE];
  logic [31:0]         v1_d    [RS_SIZE];
  logic [31:0]         v2_q    [RS_SIZE];
  logic [31:0]         v2_d    [RS_SIZE];
  logic [ROB_ID_W-1:0] q1_q    [RS_SIZE];
  logic [ROB_ID_W-1:0] q1_d    [RS_SIZE];
  logic [ROB_ID_W-1:0] q2_q    [RS_SIZE];
  logic [ROB_ID_W-1:0] q2_d    [RS_SIZE];
  logic [31:0]         imm_q   [RS_SIZE];
  logic [31:0]         imm_d   [RS_SIZE];
  logic [31:0]         pc_q    [RS_SIZE];
  logic [31:0]         pc_d    [RS_SIZE];
  logic [ROB_ID_W-1:0] rob_q   [RS_SIZE];
  logic [ROB_ID_W-1:0] rob_d   [RS_SIZE];

  // Issue output registers
  logic [OPNUM_W-1:0]  ex_opnum_q, ex_opnum_d;
  logic [31:0]         ex_v1_q, ex_v1_d;
  logic [31:0]         ex_v2_q, ex_v2_d;
  logic [31:0]         ex_imm_q, ex_imm_d;
  logic [31:0]         ex_pc_q, ex_pc_d;
  logic [ROB_ID_W-1:0] ex_rob_q, ex_rob_d;

  logic [RS_SIZE-1:0]  ready;
  logic                iss_vld;
  logic [IDX_W-1:0]    iss_idx;
  logic                alloc_vld;
  logic [IDX_W-1:0]    alloc_idx;
  logic [CNT_W-1:0]    free_cnt;

  // Returns {still_waiting, value}; ALU wins when both broadcasts carry the tag.
  function automatic logic [32:0] resolve(
    input logic                w,
    input logic [ROB_ID_W-1:0] q,
    input logic [31:0]         v,
    input logic                av,
    input logic [ROB_ID_W-1:0] aid,
    input logic [31:0]         ad,
    input logic                lv,
    input logic [ROB_ID_W-1:0] lid,
    input logic [31:0]         ld
  );
    logic [32:0] r;
    r = {w, v};
    if (w) begin
      if (av && (aid == q)) begin
        r = {1'b0, ad};
      end else if (lv && (lid == q)) begin
        r = {1'b0, ld};
      end
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
      assign ready[gi] = busy_q[gi] & ~w1_q[gi] & ~w2_q[gi];
    end
  endgenerate

  // Priority pickers over start-of-cycle state; descending scan leaves the lowest index.
  always_comb begin
    iss_vld   = 1'b0;
    iss_idx   = '0;
    alloc_vld = 1'b0;
    alloc_idx = '0;
    free_cnt  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_vld = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        alloc_vld = 1'b1;
        alloc_idx = IDX_W'(i);
        free_cnt  = free_cnt + CNT_W'(1);
      end
    end
  end

  // One slot of margin covers the dispatcher's registered request.
  assign full_to_dsp = (free_cnt <= CNT_W'(1));

  always_comb begin
    busy_d     = busy_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    opnum_d    = opnum_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    q1_d       = q1_q;
    q2_d       = q2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rob_d      = rob_q;
    ex_opnum_d = OPNUM_NULL;
    ex_v1_d    = ex_v1_q;
    ex_v2_d    = ex_v2_q;
    ex_imm_d   = ex_imm_q;
    ex_pc_d    = ex_pc_q;
    ex_rob_d   = ex_rob_q;

    if (rollback) begin
      busy_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {w1_d[i], v1_d[i]} = resolve(w1_q[i], q1_q[i], v1_q[i],
                                       alu_valid, alu_rob_id, alu_data,
                                       lsb_valid, lsb_rob_id, lsb_data);
          {w2_d[i], v2_d[i]} = resolve(w2_q[i], q2_q[i], v2_q[i],
                                       alu_valid, alu_rob_id, alu_data,
                                       lsb_valid, lsb_rob_id, lsb_data);
        end
      end

      if (iss_vld) begin
        busy_d[iss_idx] = 1'b0;
        ex_opnum_d      = opnum_q[iss_idx];
        ex_v1_d         = v1_q[iss_idx];
        ex_v2_d         = v2_q[iss_idx];
        ex_imm_d        = imm_q[iss_idx];
        ex_pc_d         = pc_q[iss_idx];
        ex_rob_d        = rob_q[iss_idx];
      end

      // Allocation only sees slots free at cycle start, so it never collides with issue.
      if (en_from_dsp && alloc_vld) begin
        busy_d[alloc_idx]  = 1'b1;
        opnum_d[alloc_idx] = opnum_from_dsp;
        q1_d[alloc_idx]    = Q1_from_dsp;
        q2_d[alloc_idx]    = Q2_from_dsp;
        imm_d[alloc_idx]   = imm_from_dsp;
        pc_d[alloc_idx]    = pc_from_dsp;
        rob_d[alloc_idx]   = rob_id_from_dsp;
        {w1_d[alloc_idx], v1_d[alloc_idx]} =
          resolve(W1_from_dsp, Q1_from_dsp, V1_from_dsp,
                  alu_valid, alu_rob_id, alu_data,
                  lsb_valid, lsb_rob_id, lsb_data);
        {w2_d[alloc_idx], v2_d[alloc_idx]} =
          resolve(W2_from_dsp, Q2_from_dsp, V2_from_dsp,
                  alu_valid, alu_rob_id, alu_data,
                  lsb_valid, lsb_rob_id, lsb_data);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        opnum_q[i] <= OPNUM_NULL;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        q1_q[i]    <= '0;
        q2_q[i]    <= '0;
        imm_q[i]   <= '0;
        pc_q[i]    <= '0;
        rob_q[i]   <= '0;
      end
      ex_opnum_q <= OPNUM_NULL;
      ex_v1_q    <= '0;
      ex_v2_q    <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      ex_rob_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      opnum_q    <= opnum_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rob_q      <= rob_d;
      ex_opnum_q <= ex_opnum_d;
      ex_v1_q    <= ex_v1_d;
      ex_v2_q    <= ex_v2_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
      ex_rob_q   <= ex_rob_d;
    end
  end

  assign opnum_to_ex  = ex_opnum_q;
  assign V1_to_ex     = ex_v1_q;
  assign V2_to_ex     = ex_v2_q;
  assign imm_to_ex    = ex_imm_q;
  assign pc_to_ex     = ex_pc_q;
  assign rob_id_to_ex = ex_rob_q;

endmodule
`default_nettype wire
